// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe move controller: FSM states,
// error codes and board geometry.
package ttt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_P_TURN = 2'd1,
    ST_C_TURN = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_OCC   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  localparam int POS_MIN = 1;
  localparam int POS_MAX = 9;
  localparam int CELLS   = 9;

endpackage

// File: rtl/ttt_move_check.sv
// Combinational legality check for one offered move code against the
// current occupancy mask. One instance serves both player and computer.
module ttt_move_check
  import ttt_pkg::*;
#(
  parameter int POS_W = 4
) (
  input  logic [POS_W-1:0] i_code,
  input  logic [CELLS-1:0] i_occ,
  output logic             o_legal,
  output logic [1:0]       o_err_code
);

  logic w_in_range;
  logic w_taken;

  // Range test first, then occupancy of the addressed cell.
  always_comb begin
    w_in_range = (i_code >= POS_W'(POS_MIN)) && (i_code <= POS_W'(POS_MAX));
    w_taken    = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      w_taken = w_taken | ((i_code == POS_W'(i + 1)) & i_occ[i]);
    end
    if (!w_in_range) begin
      o_legal    = 1'b0;
      o_err_code = ERR_RANGE;
    end else if (w_taken) begin
      o_legal    = 1'b0;
      o_err_code = ERR_OCC;
    end else begin
      o_legal    = 1'b1;
      o_err_code = ERR_NONE;
    end
  end

endmodule

// File: rtl/tic_tac_toe_move_ctrl.sv
// Move-sequencing front end for the tic_tac_toe core. Enforces turn order,
// cell range and occupancy, counts moves and ends the game on a win or a
// full board. Optional player-turn timeout: define MOVE_TIMEOUT_EN.
module tic_tac_toe_move_ctrl
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int POS_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             p_valid,
  input  logic [POS_W-1:0] p_pos,
  output logic             p_ready,
  input  logic             c_valid,
  input  logic [POS_W-1:0] c_pos,
  output logic             c_ready,
  input  logic             game_over,
  output logic             play,
  output logic [POS_W-1:0] player_pos,
  output logic [POS_W-1:0] comp_pos,
  output logic             ack,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             turn,
  output logic             busy,
  output logic [CELLS-1:0] occ
);

  state_e           r_state, w_state_nxt;
  logic [CELLS-1:0] r_occ, w_occ_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [POS_W-1:0] r_player_pos, w_player_pos_nxt;
  logic [POS_W-1:0] r_comp_pos, w_comp_pos_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_err, w_err_nxt;
  logic [1:0]       r_err_code, w_err_code_nxt;
  logic             r_turn, w_turn_nxt;
  logic             r_play, w_play_nxt;
  logic             r_p_ready, r_c_ready, r_busy;

  logic             w_is_player;
  logic             w_hs;
  logic [POS_W-1:0] w_code;
  logic [CELLS-1:0] w_mask;
  logic             w_legal;
  logic [1:0]       w_chk_code;
  logic             w_tmo_fire;

  assign w_is_player = (r_state == ST_P_TURN);
  assign w_hs        = (w_is_player && p_valid) || ((r_state == ST_C_TURN) && c_valid);
  assign w_code      = w_is_player ? p_pos : c_pos;

  ttt_move_check #(.POS_W(POS_W)) u_check (
    .i_code     (w_code),
    .i_occ      (r_occ),
    .o_legal    (w_legal),
    .o_err_code (w_chk_code)
  );

  // One-hot cell mask for the offered code (only used when legal).
  always_comb begin
    w_mask = {CELLS{1'b0}};
    for (int i = 0; i < CELLS; i++) begin
      w_mask[i] = (w_code == POS_W'(i + 1));
    end
  end

`ifdef MOVE_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;

  assign w_tmo_fire = w_is_player && (r_tmo_cnt == 32'(TIMEOUT_CYC - 1));

  // Idle cycles spent in the player turn; any player handshake restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= 32'd0;
    end else if (!w_is_player || start || game_over || w_hs || w_tmo_fire) begin
      r_tmo_cnt <= 32'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end
`else
  assign w_tmo_fire = 1'b0;

  // TIMEOUT_CYC only matters with the timeout built; keep it referenced.
  if (TIMEOUT_CYC < 1) begin : g_tmo_cfg_unused
  end
`endif

  // Next state and next output values; start > game_over > move > timeout.
  always_comb begin
    w_state_nxt      = r_state;
    w_occ_nxt        = r_occ;
    w_cnt_nxt        = r_cnt;
    w_player_pos_nxt = r_player_pos;
    w_comp_pos_nxt   = r_comp_pos;
    w_ack_nxt        = 1'b0;
    w_err_nxt        = 1'b0;
    w_err_code_nxt   = r_err_code;
    w_turn_nxt       = r_turn;
    w_play_nxt       = 1'b0;
    if (start) begin
      w_state_nxt      = ST_P_TURN;
      w_occ_nxt        = {CELLS{1'b0}};
      w_cnt_nxt        = 4'd0;
      w_player_pos_nxt = {POS_W{1'b0}};
      w_comp_pos_nxt   = {POS_W{1'b0}};
      w_turn_nxt       = 1'b0;
      w_play_nxt       = 1'b1;
    end else begin
      case (r_state)
        ST_P_TURN, ST_C_TURN: begin
          if (game_over) begin
            w_state_nxt = ST_DONE;
          end else if (w_hs && w_legal) begin
            w_occ_nxt  = r_occ | w_mask;
            w_cnt_nxt  = r_cnt + 4'd1;
            w_ack_nxt  = 1'b1;
            w_turn_nxt = ~r_turn;
            if (w_is_player) begin
              w_player_pos_nxt = p_pos;
              w_state_nxt      = ST_C_TURN;
            end else begin
              w_comp_pos_nxt = c_pos;
              w_state_nxt    = ST_P_TURN;
            end
            if (r_cnt == 4'd8) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = w_state_nxt;
            end
          end else if (w_hs) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = w_chk_code;
          end else if (w_tmo_fire) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_TMO;
            w_turn_nxt     = 1'b1;
            w_state_nxt    = ST_C_TURN;
          end else begin
            w_state_nxt = r_state;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_occ        <= {CELLS{1'b0}};
      r_cnt        <= 4'd0;
      r_player_pos <= {POS_W{1'b0}};
      r_comp_pos   <= {POS_W{1'b0}};
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'd0;
      r_turn       <= 1'b0;
      r_play       <= 1'b0;
      r_p_ready    <= 1'b0;
      r_c_ready    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_occ        <= w_occ_nxt;
      r_cnt        <= w_cnt_nxt;
      r_player_pos <= w_player_pos_nxt;
      r_comp_pos   <= w_comp_pos_nxt;
      r_ack        <= w_ack_nxt;
      r_err        <= w_err_nxt;
      r_err_code   <= w_err_code_nxt;
      r_turn       <= w_turn_nxt;
      r_play       <= w_play_nxt;
      r_p_ready    <= (w_state_nxt == ST_P_TURN);
      r_c_ready    <= (w_state_nxt == ST_C_TURN);
      r_busy       <= (w_state_nxt == ST_P_TURN) || (w_state_nxt == ST_C_TURN);
    end
  end

  assign p_ready    = r_p_ready;
  assign c_ready    = r_c_ready;
  assign play       = r_play;
  assign player_pos = r_player_pos;
  assign comp_pos   = r_comp_pos;
  assign ack        = r_ack;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign turn       = r_turn;
  assign busy       = r_busy;
  assign occ        = r_occ;

endmodule

// File: tb/tb_tic_tac_toe_move_ctrl.sv
// Self-checking bench for tic_tac_toe_move_ctrl: a board-level game model
// checked every cycle plus directed literal expectations.
module tb_tic_tac_toe_move_ctrl;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, p_valid = 1'b0, c_valid = 1'b0, game_over = 1'b0;
  logic [3:0] p_pos = 4'd0, c_pos = 4'd0;
  logic       p_ready, c_ready, play, ack, err, turn, busy;
  logic [3:0] player_pos, comp_pos;
  logic [1:0] err_code;
  logic [8:0] occ;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  tic_tac_toe_move_ctrl #(.TIMEOUT_CYC(TMO), .POS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p_valid(p_valid), .p_pos(p_pos), .p_ready(p_ready),
    .c_valid(c_valid), .c_pos(c_pos), .c_ready(c_ready),
    .game_over(game_over), .play(play),
    .player_pos(player_pos), .comp_pos(comp_pos),
    .ack(ack), .err(err), .err_code(err_code),
    .turn(turn), .busy(busy), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game model: board of owners, not FSM states ----------
  int m_board [9];    // 0 empty, 1 player, 2 computer
  int m_moves;
  bit m_live;         // a game is in progress
  bit m_comp_turn;
  bit m_play, m_ack, m_err;
  int m_err_code, m_ppos, m_cpos, m_idle;
  int m_code;

  always_comb m_code = m_comp_turn ? int'(c_pos) : int'(p_pos);

  // Advance the model on every clock edge from the sampled inputs.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_board[i]) m_board[i] <= 0;
      m_moves <= 0; m_live <= 1'b0; m_comp_turn <= 1'b0;
      m_play <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
      m_err_code <= 0; m_ppos <= 0; m_cpos <= 0; m_idle <= 0;
    end else begin
      m_play <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
      if (start) begin
        foreach (m_board[i]) m_board[i] <= 0;
        m_moves <= 0; m_live <= 1'b1; m_comp_turn <= 1'b0;
        m_ppos <= 0; m_cpos <= 0; m_play <= 1'b1; m_idle <= 0;
      end else if (m_live) begin
        if (game_over) begin
          m_live <= 1'b0; m_idle <= 0;
        end else if (m_comp_turn ? c_valid : p_valid) begin
          m_idle <= 0;
          if (m_code < 1 || m_code > 9) begin
            m_err <= 1'b1; m_err_code <= 1;
          end else if (m_board[m_code-1] != 0) begin
            m_err <= 1'b1; m_err_code <= 2;
          end else begin
            m_board[m_code-1] <= m_comp_turn ? 2 : 1;
            m_moves <= m_moves + 1;
            if (m_moves == 8) m_live <= 1'b0;
            if (m_comp_turn) m_cpos <= m_code; else m_ppos <= m_code;
            m_ack <= 1'b1;
            m_comp_turn <= ~m_comp_turn;
          end
        end else if (!m_comp_turn) begin
`ifdef MOVE_TIMEOUT_EN
          if (m_idle + 1 == TMO) begin
            m_err <= 1'b1; m_err_code <= 3; m_comp_turn <= 1'b1; m_idle <= 0;
          end else begin
            m_idle <= m_idle + 1;
          end
`else
          m_idle <= m_idle + 1;
`endif
        end
      end
    end
  end

  function automatic int model_occ();
    int v = 0;
    for (int i = 0; i < 9; i++) if (m_board[i] != 0) v |= (1 << i);
    return v;
  endfunction

  // Compare every output with the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_play",       int'(play),       int'(m_play));
      chk("m_ack",        int'(ack),        int'(m_ack));
      chk("m_err",        int'(err),        int'(m_err));
      chk("m_err_code",   int'(err_code),   m_err_code);
      chk("m_turn",       int'(turn),       int'(m_comp_turn));
      chk("m_busy",       int'(busy),       int'(m_live));
      chk("m_p_ready",    int'(p_ready),    int'(m_live && !m_comp_turn));
      chk("m_c_ready",    int'(c_ready),    int'(m_live && m_comp_turn));
      chk("m_occ",        int'(occ),        model_occ());
      chk("m_player_pos", int'(player_pos), m_ppos);
      chk("m_comp_pos",   int'(comp_pos),   m_cpos);
    end
  end

  // Offer one move for one cycle, then check the handshake result.
  task automatic move(input bit comp, input int code, input bit e_ack,
                      input bit e_err, input int e_code, input string tag);
    if (comp) begin c_valid = 1'b1; c_pos = 4'(code); end
    else      begin p_valid = 1'b1; p_pos = 4'(code); end
    @(negedge clk);
    p_valid = 1'b0; c_valid = 1'b0;
    chk({tag, "_ack"}, int'(ack), int'(e_ack));
    chk({tag, "_err"}, int'(err), int'(e_err));
    if (e_err) chk({tag, "_code"}, int'(err_code), e_code);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_play", int'(play), 1);
    chk("start_p_ready", int'(p_ready), 1);
    chk("start_turn", int'(turn), 0);
    chk("start_occ", int'(occ), 0);
  endtask

  int seq [9] = '{5, 1, 7, 3, 2, 8, 9, 4, 6};

  initial begin
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_play", int'(play), 0);
    chk("rst_p_ready", int'(p_ready), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    @(negedge clk);

    // Full nine-move game, no win reported.
    pulse_start();
    @(negedge clk);
    chk("play_once", int'(play), 0);
    for (int i = 0; i < 9; i++) move(i[0], seq[i], 1'b1, 1'b0, 0, "seq");
    chk("full_occ", int'(occ), 9'h1FF);
    chk("full_p_ready", int'(p_ready), 0);
    chk("full_c_ready", int'(c_ready), 0);
    chk("full_busy", int'(busy), 0);
    move(1'b0, 5, 1'b0, 1'b0, 0, "done_ignored");

    // start in the same cycle as a move: move dropped.
    p_valid = 1'b1; p_pos = 4'd5;
    pulse_start();
    p_valid = 1'b0;
    chk("start_beats_ack", int'(ack), 0);

    // Occupied cell and out-of-range codes.
    move(1'b0, 5, 1'b1, 1'b0, 0, "p5");
    move(1'b1, 5, 1'b0, 1'b1, 2, "c5_occ");
    chk("c5_turn", int'(turn), 1);
    chk("c5_comp_pos", int'(comp_pos), 0);
    move(1'b1, 1, 1'b1, 1'b0, 0, "c1");
    move(1'b0, 0, 1'b0, 1'b1, 1, "p0");
    move(1'b0, 10, 1'b0, 1'b1, 1, "p10");
    chk("range_occ", int'(occ), 9'h011);
    chk("range_p_ready", int'(p_ready), 1);
    move(1'b1, 9, 1'b0, 1'b0, 0, "c_not_ready");

    // game_over together with a computer move.
    move(1'b0, 7, 1'b1, 1'b0, 0, "p7");
    game_over = 1'b1; c_valid = 1'b1; c_pos = 4'd3;
    @(negedge clk);
    game_over = 1'b0; c_valid = 1'b0;
    chk("gover_ack", int'(ack), 0);
    chk("gover_busy", int'(busy), 0);
    chk("gover_c_ready", int'(c_ready), 0);
    chk("gover_occ", int'(occ), 9'h051);
    pulse_start();

    // Reset in the middle of a game.
    move(1'b0, 5, 1'b1, 1'b0, 0, "pre_rst");
    rst = 1'b0;
    #1;
    chk("midrst_occ", int'(occ), 0);
    chk("midrst_player_pos", int'(player_pos), 0);
    chk("midrst_turn", int'(turn), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    chk("midrst_c_ready", int'(c_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    @(negedge clk);
    chk("restart_play_once", int'(play), 0);

    // Idle player: the game entered P_TURN one edge before pulse_start
    // returned, and one more edge has passed since.
`ifdef MOVE_TIMEOUT_EN
    repeat (TMO - 2) @(negedge clk);
    chk("tmo_not_yet", int'(err), 0);
    @(negedge clk);
    chk("tmo_err", int'(err), 1);
    chk("tmo_code", int'(err_code), 3);
    chk("tmo_turn", int'(turn), 1);
    chk("tmo_c_ready", int'(c_ready), 1);
    chk("tmo_occ", int'(occ), 0);
`else
    repeat (3 * TMO) @(negedge clk);
    chk("no_tmo_err", int'(err), 0);
    chk("no_tmo_p_ready", int'(p_ready), 1);
`endif
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tic_tac_toe_move_ctrl.md
# tic_tac_toe_move_ctrl

Move-sequencing front end for the `tic_tac_toe` game core. Accepts player and computer move requests over valid/ready handshakes and enforces turn alternation, cell range and cell occupancy. Tracks move count and ends the game on a core-reported win or a full board. Drives the core's `play`, `player_pos` and `comp_pos` inputs with clean, registered, legal codes only.

## Interface
- `TIMEOUT_CYC`, default 1000: player-turn timeout in cycles; used only with `MOVE_TIMEOUT_EN`.
- `POS_W`, default 4: position code width; legal codes are 1..9 (cell = code−1, row-major).

Ports (all outputs registered):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: new-game request, level-sampled.
- `p_valid` in 1: player move offered.
- `p_pos` in POS_W: player move code.
- `p_ready` out 1: player move can be taken.
- `c_valid` in 1: computer move offered.
- `c_pos` in POS_W: computer move code.
- `c_ready` out 1: computer move can be taken.
- `game_over` in 1: win detected by the core, level.
- `play` out 1: one-cycle new-game pulse to the core.
- `player_pos` out POS_W: last accepted player code to the core; 0 = none.
- `comp_pos` out POS_W: last accepted computer code to the core; 0 = none.
- `ack` out 1: one-cycle pulse, move accepted.
- `err` out 1: one-cycle pulse, move rejected.
- `err_code` out 2: 1 = out of range, 2 = cell occupied, 3 = timeout; holds its value until the next `err`.
- `turn` out 1: 0 = player, 1 = computer.
- `busy` out 1: game in progress.
- `occ` out 9: occupied-cell mask, bit i = cell i.

## Operation
- State machine: IDLE → P_TURN → C_TURN → P_TURN … → DONE.
- IDLE/DONE + `start` → P_TURN: clear `occ`, move count, `player_pos` and `comp_pos`; pulse `play`.
- `p_ready` = (state == P_TURN). `c_ready` = (state == C_TURN). Both are 0 in IDLE and DONE.
- A handshake completes on a cycle with valid && ready. Legality is checked combinationally on the offered code:
  - code 0 or > 9 → `err`, `err_code` = 1.
  - cell already set in `occ` → `err`, `err_code` = 2.
  - A rejected move leaves the state unchanged; the same side keeps the turn.
- On a legal move:
  - Set the `occ` bit and increment the move count (0..9).
  - Update `player_pos` or `comp_pos`.
  - Pulse `ack` and toggle `turn`.
- A move while not ready is ignored: no `ack`, no `err`.
- After an accepted move, go to DONE if `game_over` is high or the move count reaches 9. DONE holds all outputs until `start`.
- Simultaneous events, in priority order:
  - `start` beats any move in the same cycle; the move is dropped silently.
  - `game_over` sampled high in P_TURN or C_TURN beats a concurrent move; go to DONE and drop the move silently.
- Reset is legal at any time, including mid-game. All outputs go to 0 and the state goes to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE.
- Accept latency: `ack`/`err`, updated position code, `occ` and `turn` are visible in the cycle after the accepting edge.
- `play` is high for exactly one cycle after the `start` edge.
- Back-to-back moves are allowed: `c_ready` rises in the cycle after the player `ack`.

## Configuration
- `MOVE_TIMEOUT_EN` defined:
  - A counter runs in P_TURN and resets on every player handshake.
  - When it reaches `TIMEOUT_CYC`: `err` with `err_code` = 3, turn passes to the computer, and move count and `occ` are unchanged.
- Undefined: no counter is built; the player may wait indefinitely and `err_code` 3 is never produced.

## Structure
- Shared package `ttt_pkg`:
  - State enum.
  - Error code constants.
  - `POS_MIN` = 1, `POS_MAX` = 9.
  - `CELLS` = 9.
- Sub-module `ttt_move_check`: combinational. Inputs code and `occ`; outputs legal flag and `err_code`. Shared by the player and computer paths.

## Test plan
- Reset low mid-game, then `start`: all outputs 0 while reset is low → `play` pulses once → `p_ready` = 1, `turn` = 0.
- Sequence player 5, comp 1, player 7, comp 3, player 2, comp 8, player 9, comp 4, player 6 with `game_over` = 0: nine `ack` pulses; `occ` = 0x1FF; DONE after the ninth move; `p_ready` = `c_ready` = 0.
- Player 5 accepted, then comp 5: `err`, `err_code` = 2; `turn` stays 1; `comp_pos` stays 0.
- Player codes 0, then 10: each gives `err`, `err_code` = 1; `occ` unchanged; `p_ready` stays 1.
- `game_over` raised in the same cycle as a computer move: move dropped (no `ack`), DONE next cycle; `start` begins a new game with `occ` = 0.
- With `MOVE_TIMEOUT_EN` and `TIMEOUT_CYC` = 8, player idle for 8 cycles: `err`, `err_code` = 3, then `turn` = 1 and `c_ready` = 1.
